// File: rtl/lm96570_spi_sequencer.sv
// LM96570 serial-interface sequencer.
// Takes one register-access command at a time and serialises it as
// {R/W, addr[4:0], data[L-1:0]} MSB first on SCLK/SLE/SDI. On read frames the
// device's SDO is sampled on every SCLK rising cycle and the trailing L bits
// are returned right-aligned on rd_data.
//
// Handshake: a command is accepted in the cycle where cmd_valid and cmd_ready
// are both high. cmd_ready is high only in IDLE; cmd_valid seen in any other
// state is left pending (not consumed) until IDLE is reached again. All
// command fields are registered at accept.
module lm96570_spi_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [4:0]        cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              spi_sclk,
  output logic              spi_sle,
  output logic              spi_sdi,
  input  logic              spi_sdo,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                 FRAME_W    = DATA_W + 6;
  localparam logic [LEN_W-1:0]   DATA_W_L   = LEN_W'(DATA_W);
  localparam logic [7:0]         DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [LEN_W:0]     HDR_BITS   = (LEN_W+1)'(6);
  localparam logic [LEN_W:0]     ONE_BIT    = (LEN_W+1)'(1);

  state_t              state_q;
  logic [7:0]          div_q;       // clk cycles left in current SCLK phase
  logic [LEN_W:0]      bits_q;      // SCLK falls still to come
  logic [LEN_W-1:0]    len_q;       // clamped data length of current frame
  logic [FRAME_W-1:0]  shift_q;     // remaining frame bits, next bit at MSB
  logic [DATA_W-1:0]   rx_q;        // every SDO sample of the frame
  logic                sample_q;    // current cycle is an SCLK rising cycle
  logic                read_q;
  logic                sclk_q;
  logic                sle_q;
  logic                sdi_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_valid_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [LEN_W-1:0]    len_c;
  logic [DATA_W-1:0]   data_left_c;
  logic [FRAME_W-1:0]  frame_c;
  logic [DATA_W-1:0]   rx_mask_c;

  // Clamp the length, left-align the frame so bit N-1 sits at the MSB, and
  // build the mask that keeps only the L data samples of a read.
  always_comb begin
    len_c = cmd_len;
    if (cmd_len == '0 || cmd_len > DATA_W_L) len_c = DATA_W_L;
    data_left_c = cmd_read ? '0 : (cmd_wdata << (DATA_W_L - len_c));
    frame_c     = {cmd_read, cmd_addr, data_left_c};
    rx_mask_c   = {DATA_W{1'b1}} >> (DATA_W_L - len_q);
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> DONE, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bits_q     <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      sample_q   <= 1'b0;
      read_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sle_q      <= 1'b0;
      sdi_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      rd_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      sample_q   <= 1'b0;
      if (sample_q) rx_q <= {rx_q[DATA_W-2:0], spi_sdo};

      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            shift_q <= frame_c << 1;
            sdi_q   <= frame_c[FRAME_W-1];
            bits_q  <= {1'b0, len_c} + HDR_BITS;
            len_q   <= len_c;
            read_q  <= cmd_read;
            div_q   <= DIV_RELOAD;
            sle_q   <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (div_q == '0) begin
            sclk_q   <= 1'b1;
            sample_q <= 1'b1;
            div_q    <= DIV_RELOAD;
            state_q  <= S_SHIFT;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end

        S_SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - 8'd1;
          end else begin
            div_q <= DIV_RELOAD;
            if (sclk_q) begin
              // Falling edge: present the next bit, or park SDI low after the last.
              sclk_q  <= 1'b0;
              bits_q  <= bits_q - ONE_BIT;
              shift_q <= shift_q << 1;
              sdi_q   <= (bits_q == ONE_BIT) ? 1'b0 : shift_q[FRAME_W-1];
            end else if (bits_q != '0) begin
              sclk_q   <= 1'b1;
              sample_q <= 1'b1;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (div_q == '0) begin
            sle_q      <= 1'b0;
            done_q     <= 1'b1;
            rd_valid_q <= read_q;
            if (read_q) rd_data_q <= rx_q & rx_mask_c;
            state_q    <= S_DONE;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign spi_sclk    = sclk_q;
  assign spi_sle     = sle_q;
  assign spi_sdi     = sdi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lm96570_spi_sequencer.sv
// Bench for lm96570_spi_sequencer (CLK_DIV=2, DATA_W=32, LEN_W=6).
// A timing model derives every output from the accept cycle and the frame
// contents, and is compared against the DUT on every cycle; directed frames
// add hand-computed expectations for SDI streams, rise counts and latencies.
module tb_lm96570_spi_sequencer;

  localparam int C  = 2;
  localparam int DW = 32;
  localparam int LW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [4:0]    cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          spi_sclk;
  logic          spi_sle;
  logic          spi_sdi;
  logic          spi_sdo = 1'b0;
  logic          busy;
  logic          done;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [2:0]    dbg_state;

  lm96570_spi_sequencer #(.CLK_DIV(C), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_read    (cmd_read),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_wdata   (cmd_wdata),
    .spi_sclk    (spi_sclk),
    .spi_sle     (spi_sle),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo),
    .busy        (busy),
    .done        (done),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lmask(input int l);
    return (64'd1 << l) - 64'd1;
  endfunction

  // ---------------- model ----------------
  int          cyc     = 0;
  bit          armed   = 1'b0;
  bit          m_act   = 1'b0;
  int          m_t     = 0;
  int          m_n     = 6;
  int          m_l     = 0;
  bit          m_rd    = 1'b0;
  logic [63:0] m_frame = '0;
  logic [31:0] m_rdata = '0;
  logic [63:0] sdo_bits = '0;   // bit N-1-k is returned on SCLK rise k
  int          acc_cnt = 0;

  // Tracks accepted frames by cycle number; retires them after the done cycle.
  always @(posedge clk) begin
    logic [63:0] msk;
    if (reset) begin
      m_act   = 1'b0;
      m_rdata = '0;
      armed   = 1'b1;
    end else if (armed) begin
      if (!m_act && cmd_valid) begin
        m_l = (cmd_len == 0 || cmd_len > DW) ? DW : int'(cmd_len);
        m_n = m_l + 6;
        m_rd = cmd_read;
        msk = lmask(m_l);
        m_frame = ({58'd0, cmd_read, cmd_addr} << m_l) |
                  (cmd_read ? 64'd0 : ({32'd0, cmd_wdata} & msk));
        m_t = cyc;
        m_act = 1'b1;
        acc_cnt++;
      end else if (m_act && (cyc - m_t) == 1 + C * (2 * m_n + 2)) begin
        msk = lmask(m_l);
        if (m_rd) m_rdata = sdo_bits[31:0] & msk[31:0];
        m_act = 1'b0;
      end
    end
    cyc++;
  end

  // Device SDO: a fresh bit is presented on every SCLK rise.
  int sdo_k   = 0;
  int sdo_acc = 0;
  always @(posedge spi_sclk) begin
    int idx;
    if (sdo_acc != acc_cnt) begin
      sdo_acc = acc_cnt;
      sdo_k   = 0;
    end
    idx = m_n - 1 - sdo_k;
    spi_sdo = (idx >= 0 && idx < 64) ? sdo_bits[idx] : 1'b0;
    sdo_k++;
  end

  // ---------------- per-cycle compare and frame monitors ----------------
  int          rises = 0, done_cnt = 0, rv_cnt = 0, rv_cyc = -1, done_cyc = -1;
  int          mon_acc = 0, low_run = 0, last_gap = 0, done_rises = 0;
  logic [63:0] sdi_word = '0, done_sdi = '0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    int d, j, bi, dd;
    logic [38:0] e, a;
    logic [63:0] msk;
    logic [31:0] e_rd;
    logic e_ready, e_sclk, e_sle, e_sdi, e_busy, e_done, e_rv;
    if (armed) begin
      e_ready = !m_act; e_sclk = 1'b0; e_sle = 1'b0; e_sdi = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_rv = 1'b0; e_rd = m_rdata;
      if (m_act) begin
        d  = cyc - m_t;
        dd = 1 + C * (2 * m_n + 2);
        e_busy = 1'b1;
        if (d >= dd) begin
          e_done = 1'b1;
          e_rv   = m_rd;
          msk    = lmask(m_l);
          if (m_rd) e_rd = sdo_bits[31:0] & msk[31:0];
        end else begin
          e_sle = 1'b1;
          if (d <= C) begin
            e_sdi = m_frame[m_n-1];
          end else begin
            j = (d - 1 - C) / C;       // SCLK half-period index, 0 = first high
            if (j < 2 * m_n) begin
              e_sclk = (j % 2 == 0);
              bi = m_n - 1 - (j + 1) / 2;
              e_sdi = (bi >= 0) ? m_frame[bi] : 1'b0;
            end
          end
        end
      end
      e = {e_ready, e_sclk, e_sle, e_sdi, e_busy, e_done, e_rv, e_rd};
      a = {cmd_ready, spi_sclk, spi_sle, spi_sdi, busy, done, rd_valid, rd_data};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle %0d outputs {ready,sclk,sle,sdi,busy,done,rd_valid,rd_data}: got %h expected %h",
                 cyc, a, e);
      end

      if (acc_cnt != mon_acc) begin
        mon_acc  = acc_cnt;
        rises    = 0;
        sdi_word = '0;
      end
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        sdi_word = {sdi_word[62:0], spi_sdi};
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc   = cyc;
        done_sdi   = sdi_word;
        done_rises = rises;
      end
      if (rd_valid === 1'b1) begin
        rv_cnt++;
        rv_cyc = cyc;
      end
      if (spi_sle !== 1'b1) low_run++;
      else if (low_run != 0) begin
        last_gap = low_run;
        low_run  = 0;
      end
    end
    prev_sclk = spi_sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic rd, input logic [4:0] addr, input logic [LW-1:0] len,
                      input logic [DW-1:0] wd, input bit keep, output int t_acc);
    int start;
    start = acc_cnt;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_cnt == start; i++) @(negedge clk);
    check("accept_seen", (acc_cnt != start) ? 64'd1 : 64'd0, 64'd1);
    if (!keep) cmd_valid = 1'b0;
    t_acc = m_t;
  endtask

  task automatic wait_done(input int start_cnt);
    for (int i = 0; i < 2000 && done_cnt == start_cnt; i++) @(negedge clk);
    check("done_seen", (done_cnt != start_cnt) ? 64'd1 : 64'd0, 64'd1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, dc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;

    // Reset for 3 cycles
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_sclk",      spi_sclk,  0);
    check("rst_sle",       spi_sle,   0);
    check("rst_sdi",       spi_sdi,   0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_rd_data",   rd_data,   0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Write addr 03, len 16, wdata A5C3 (upper junk must not be sent)
    dc = done_cnt;
    send(1'b0, 5'h03, 6'd16, 32'hFFFF_A5C3, 1'b0, t);
    wait_done(dc);
    check("wr_sdi_stream", done_sdi, 64'b0_00011_1010010111000011);
    check("wr_rises",      done_rises, 22);
    check("wr_latency",    done_cyc - t, 93);
    check("wr_no_rvalid",  rv_cnt, 0);
    check("wr_rd_data",    rd_data, 0);

    // Read addr 1F, len 8, device returns 6B after a non-zero header
    sdo_bits = {50'd0, 6'b101010, 8'h6B};
    dc = done_cnt;
    send(1'b1, 5'h1F, 6'd8, 32'hDEAD_BEEF, 1'b0, t);
    wait_done(dc);
    check("rd_data_6b",    rd_data, 32'h0000_006B);
    check("rd_latency",    done_cyc - t, 61);
    check("rd_sdi_stream", done_sdi, 64'b1_11111_00000000);
    check("rd_rises",      done_rises, 14);
    check("rd_rvalid_cnt", rv_cnt, 1);
    check("rd_rvalid_cyc", rv_cyc, done_cyc);

    // Length clamping: 0 and 40 both become 32 data bits
    dc = done_cnt;
    send(1'b0, 5'h0C, 6'd0, $urandom, 1'b0, t);
    wait_done(dc);
    check("len0_rises",   done_rises, 38);
    check("len0_latency", done_cyc - t, 157);
    sdo_bits = {$urandom, $urandom};
    dc = done_cnt;
    send(1'b1, 5'h12, 6'd40, 32'h0, 1'b0, t);
    wait_done(dc);
    check("len40_rises",   done_rises, 38);
    check("len40_rd_data", rd_data, sdo_bits[31:0]);

    // Back-to-back with cmd_valid held; fields change right after accept
    dc = done_cnt;
    send(1'b0, 5'h0A, 6'd4, 32'h5, 1'b1, t);
    send(1'b0, 5'h15, 6'd4, 32'hA, 1'b0, t2);
    check("b2b_accept_cyc", t2, done_cyc + 1);
    check("b2b_frame1_sdi", done_sdi, 64'b0_01010_0101);
    repeat (2) @(negedge clk);
    check("b2b_sle_gap_min", (last_gap >= 1) ? 64'd1 : 64'd0, 64'd1);
    wait_done(dc + 1);
    check("b2b_frame2_sdi", done_sdi, 64'b0_10101_1010);

    // Reset in the middle of SHIFT after 10 rises
    sdo_bits = {$urandom, $urandom};
    send(1'b1, 5'h07, 6'd16, 32'h0, 1'b0, t);
    for (int i = 0; i < 2000 && rises < 10; i++) @(negedge clk);
    check("mid_rises_reached", (rises >= 10) ? 64'd1 : 64'd0, 64'd1);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_sle",     spi_sle,  0);
    check("mid_rst_sclk",    spi_sclk, 0);
    check("mid_rst_busy",    busy,     0);
    check("mid_rst_rd_data", rd_data,  0);
    repeat (100) @(negedge clk);
    check("mid_rst_no_done", done_cnt, dc);
    sdo_bits = {46'd0, 6'b110011, 12'hC35};
    send(1'b1, 5'h11, 6'd12, 32'hFFFF_FFFF, 1'b0, t);
    wait_done(dc);
    check("post_rst_rd_data", rd_data, 32'h0000_0C35);
    check("post_rst_sdi",     done_sdi, 64'b1_10001_000000000000);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

endmodule
